cache_mem_responder: RTL and testbench

- Synthesizable responder for the DCache2Way memory port. It answers m_access requests from the cache with a registered, single-cycle m_ack pulse.
- Backed by a word-wide block RAM with byte-enable writes and programmable wait states.
- Used as the memory-side endpoint in cache benches. Also used as a stand-in for the SDRAM controller in FPGA bring-up builds.

---
 rtl/cache_mem_responder.sv | 202 ++++++++++++++++++++
 tb/tb_cache_mem_responder.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_responder.sv
// Memory-port responder for the 2-way data cache: block RAM with byte-enable writes and counters.
// Latency: WAIT_STATES+1 cycles from the sampling edge to m_ack; one transaction per WAIT_STATES+2 cycles.
// Backpressure: the cache holds m_access until m_ack; requests are not re-sampled in WAIT or ACK.
// Optional build macro RESP_STALL_EN: an LFSR adds 0..3 random extra wait cycles per request.
module cache_mem_responder #(
    parameter int          DEPTH_W     = 11,
    parameter int          WAIT_STATES = 0,
    parameter logic [15:0] INIT_WORD   = 16'hAAAA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:1] m_addr,
    input  logic [15:0] m_data_out,
    input  logic        m_access,
    input  logic        m_wr_en,
    input  logic [1:0]  m_bytesel,
    output logic [15:0] m_data_in,
    output logic        m_ack,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic        oor_err
);

    localparam int WORDS = 1 << DEPTH_W;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t        state_q, state_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [19:1]   addr_q, addr_d;
    logic [15:0]   wdat_q, wdat_d;
    logic          wr_q, wr_d;
    logic [1:0]    be_q, be_d;
    logic [15:0]   m_data_in_q, m_data_in_d;
    logic [15:0]   rd_count_q, rd_count_d;
    logic [15:0]   wr_count_q, wr_count_d;
    logic          oor_q, oor_d;

    logic [19:1]   req_addr;
    logic [15:0]   req_wdat;
    logic          req_wr;
    logic [1:0]    req_be;
    logic          req_oor;
    logic [DEPTH_W-1:0] req_idx;
    logic          fire;
    logic          ram_we;
    logic [4:0]    wait_total;

    logic [15:0]   mem [0:WORDS-1];

    // Power-up contents come from the FPGA bitstream; reset deliberately leaves the RAM alone.
    initial begin
        for (int i = 0; i < WORDS; i++) begin
            mem[i] = INIT_WORD;
        end
    end

`ifdef RESP_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR (taps 8,6,5,4) free-runs; its low bits pick the per-request extra stall.
    always_comb begin
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        wait_total = 5'(WAIT_STATES) + {3'b000, lfsr_q[1:0]};
    end

    // LFSR register, reseeded on reset so stall patterns repeat run to run.
    always_ff @(posedge clk) begin
        if (reset) lfsr_q <= 8'hA5;
        else       lfsr_q <= lfsr_d;
    end
`else
    // Fixed wait budget when random stalling is not built in.
    always_comb begin
        wait_total = 5'(WAIT_STATES);
    end
`endif

    // The ack edge may coincide with the sampling edge (no waits), so use live inputs while idle.
    always_comb begin
        if (state_q == S_IDLE) begin
            req_addr = m_addr;
            req_wdat = m_data_out;
            req_wr   = m_wr_en;
            req_be   = m_bytesel;
        end else begin
            req_addr = addr_q;
            req_wdat = wdat_q;
            req_wr   = wr_q;
            req_be   = be_q;
        end
        req_idx = req_addr[DEPTH_W:1];
        req_oor = |req_addr[19:DEPTH_W+1];
    end

    // FSM state register; the wait counter moves with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // FSM next state: accept in IDLE, count down in WAIT, always leave ACK after one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (m_access) begin
                    if (wait_total == 5'd0) begin
                        state_d = S_ACK;
                    end else begin
                        cnt_d   = wait_total - 5'd1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 5'd0) state_d = S_ACK;
                else               cnt_d   = cnt_q - 5'd1;
            end
            S_ACK:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: ack is a decode of the ACK state; the RAM operation happens on the edge entering ACK.
    always_comb begin
        m_ack = (state_q == S_ACK);
        fire  = (state_d == S_ACK) && !reset;
    end

    // Request capture, read data, counters and the sticky out-of-range flag.
    always_comb begin
        addr_d      = addr_q;
        wdat_d      = wdat_q;
        wr_d        = wr_q;
        be_d        = be_q;
        m_data_in_d = m_data_in_q;
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        oor_d       = oor_q;
        ram_we      = 1'b0;
        if (state_q == S_IDLE && m_access) begin
            addr_d = m_addr;
            wdat_d = m_data_out;
            wr_d   = m_wr_en;
            be_d   = m_bytesel;
        end
        if (fire) begin
            oor_d = oor_q | req_oor;
            if (req_wr) begin
                ram_we = !req_oor;
                if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
            end else begin
                m_data_in_d = req_oor ? 16'hFFFF : mem[req_idx];
                if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q      <= '0;
            wdat_q      <= '0;
            wr_q        <= 1'b0;
            be_q        <= '0;
            m_data_in_q <= '0;
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            oor_q       <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            wdat_q      <= wdat_d;
            wr_q        <= wr_d;
            be_q        <= be_d;
            m_data_in_q <= m_data_in_d;
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            oor_q       <= oor_d;
        end
    end

    // Byte-masked RAM write; bytesel 2'b00 writes nothing but still counts as a write.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            if (req_be[0]) mem[req_idx][7:0]  <= req_wdat[7:0];
            if (req_be[1]) mem[req_idx][15:8] <= req_wdat[15:8];
        end
    end

    assign m_data_in = m_data_in_q;
    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
    assign oor_err   = oor_q;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: one zero-wait instance and one three-wait instance.
// Read expectations go through a scoreboard queue and are popped when the ack arrives.
// Shared address/data buses; each instance has its own m_access.
module tb_cache_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_access0, m_access3, m_wr_en;
    logic [18:0] m_addr;
    logic [15:0] m_data_out;
    logic [1:0]  m_bytesel;

    logic [15:0] d0_data, d0_rd, d0_wr, d3_data, d3_rd, d3_wr;
    logic        d0_ack, d0_oor, d3_ack, d3_oor;

    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];
    int lat_a[64];
    int lat_b[64];

    always #5 clk = ~clk;

    cache_mem_responder #(.DEPTH_W(11), .WAIT_STATES(0), .INIT_WORD(16'hAAAA)) u_ws0 (
        .clk(clk), .reset(reset), .m_addr(m_addr), .m_data_out(m_data_out),
        .m_access(m_access0), .m_wr_en(m_wr_en), .m_bytesel(m_bytesel),
        .m_data_in(d0_data), .m_ack(d0_ack), .rd_count(d0_rd), .wr_count(d0_wr),
        .oor_err(d0_oor));

    cache_mem_responder #(.DEPTH_W(11), .WAIT_STATES(3), .INIT_WORD(16'hAAAA)) u_ws3 (
        .clk(clk), .reset(reset), .m_addr(m_addr), .m_data_out(m_data_out),
        .m_access(m_access3), .m_wr_en(m_wr_en), .m_bytesel(m_bytesel),
        .m_data_in(d3_data), .m_ack(d3_ack), .rd_count(d3_rd), .wr_count(d3_wr),
        .oor_err(d3_oor));

    task automatic do_reset;
        reset = 1'b1;
        m_access0 = 1'b0;
        m_access3 = 1'b0;
        m_wr_en = 1'b0;
        m_addr = '0;
        m_data_out = '0;
        m_bytesel = 2'b11;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one request, holds it until ack (bounded), returns latency and the data seen with ack.
    // After acceptance the buses are scrambled so only the latched copy can produce correct results.
    task automatic xact(input bit use3, input bit wr, input logic [18:0] addr,
                        input logic [15:0] data, input logic [1:0] be,
                        output int lat, output logic [15:0] rdata);
        @(negedge clk);
        m_addr = addr;
        m_data_out = data;
        m_wr_en = wr;
        m_bytesel = be;
        if (use3) m_access3 = 1'b1;
        else      m_access0 = 1'b1;
        lat = -1;
        rdata = 16'hxxxx;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if ((use3 ? d3_ack : d0_ack) === 1'b1) begin
                lat = i;
                rdata = use3 ? d3_data : d0_data;
                break;
            end
            m_addr = ~addr;
            m_data_out = ~data;
            m_bytesel = ~be;
        end
        m_access0 = 1'b0;
        m_access3 = 1'b0;
        if (lat < 0) begin
            checks++;
            errors++;
            $display("FAIL xact_timeout: no ack within 40 cycles for addr %h", addr);
        end
    endtask

    task automatic test_reset;
        do_reset();
        checks++;
        if ({d0_ack, d0_data, d0_rd, d0_wr, d0_oor} !== 50'd0) begin
            errors++;
            $display("FAIL reset_ws0: got ack=%b data=%h rd=%h wr=%h oor=%b, want all 0",
                     d0_ack, d0_data, d0_rd, d0_wr, d0_oor);
        end
        checks++;
        if ({d3_ack, d3_data, d3_rd, d3_wr, d3_oor} !== 50'd0) begin
            errors++;
            $display("FAIL reset_ws3: got ack=%b data=%h rd=%h wr=%h oor=%b, want all 0",
                     d3_ack, d3_data, d3_rd, d3_wr, d3_oor);
        end
    endtask

    task automatic test_rw_bytes;
        int lat;
        logic [15:0] rd, e;
        do_reset();
        exp_q.push_back(16'hAAAA);
        xact(0, 0, 19'h00020, 16'h0000, 2'b11, lat, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin errors++; $display("FAIL init_read: got %h want %h", rd, e); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL ws0_latency: got %0d want 1", lat); end
        checks++; if (d0_rd !== 16'd1) begin errors++; $display("FAIL rd_count_1: got %0d want 1", d0_rd); end
        @(negedge clk);
        checks++; if (d0_ack !== 1'b0) begin errors++; $display("FAIL ack_width: got %b want 0", d0_ack); end

        xact(0, 1, 19'h00020, 16'hDEAD, 2'b01, lat, rd);
        checks++; if (d0_data !== 16'hAAAA) begin errors++; $display("FAIL write_keeps_rdata: got %h want AAAA", d0_data); end
        exp_q.push_back(16'hAAAD);
        xact(0, 0, 19'h00020, 16'h0000, 2'b11, lat, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin errors++; $display("FAIL low_byte_write: got %h want %h", rd, e); end

        xact(0, 1, 19'h00020, 16'h1234, 2'b10, lat, rd);
        exp_q.push_back(16'h12AD);
        xact(0, 0, 19'h00020, 16'h0000, 2'b01, lat, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin errors++; $display("FAIL high_byte_write: got %h want %h", rd, e); end
        checks++; if (d0_wr !== 16'd2) begin errors++; $display("FAIL wr_count_2: got %0d want 2", d0_wr); end

        xact(0, 1, 19'h00020, 16'hFFFF, 2'b00, lat, rd);
        checks++; if (lat !== 1) begin errors++; $display("FAIL be00_ack: got latency %0d want 1", lat); end
        exp_q.push_back(16'h12AD);
        xact(0, 0, 19'h00020, 16'h0000, 2'b00, lat, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin errors++; $display("FAIL be00_nowrite: got %h want %h", rd, e); end
        checks++; if ({d0_rd, d0_wr} !== {16'd4, 16'd3}) begin
            errors++; $display("FAIL counts_after_rw: got rd=%0d wr=%0d want rd=4 wr=3", d0_rd, d0_wr);
        end
    endtask

    task automatic test_wait_hold;
        int acks, first, second;
        do_reset();
        acks = 0; first = -1; second = -1;
        @(negedge clk);
        m_addr = 19'h00030;
        m_wr_en = 1'b0;
        m_bytesel = 2'b11;
        m_access3 = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            if (d3_ack === 1'b1) begin
                acks++;
                if (acks == 1) first = k;
                if (acks == 2) begin second = k; m_access3 = 1'b0; end
            end
        end
        m_access3 = 1'b0;
        checks++; if (acks !== 2) begin errors++; $display("FAIL hold_ack_count: got %0d want 2", acks); end
        checks++; if (first !== 4) begin errors++; $display("FAIL ws3_latency: got %0d want 4", first); end
        checks++; if (second - first !== 5) begin errors++; $display("FAIL b2b_spacing: got %0d want 5", second - first); end
        checks++; if (d3_rd !== 16'd2) begin errors++; $display("FAIL hold_rd_count: got %0d want 2", d3_rd); end
        checks++; if (d3_data !== 16'hAAAA) begin errors++; $display("FAIL hold_rdata: got %h want AAAA", d3_data); end
    endtask

    task automatic test_oor;
        int lat;
        logic [15:0] rd, e;
        do_reset();
        exp_q.push_back(16'hFFFF);
        xact(0, 0, 19'h00800, 16'h0000, 2'b11, lat, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin errors++; $display("FAIL oor_read: got %h want %h", rd, e); end
        checks++; if (lat !== 1) begin errors++; $display("FAIL oor_latency: got %0d want 1", lat); end
        checks++; if (d0_oor !== 1'b1) begin errors++; $display("FAIL oor_set: got %b want 1", d0_oor); end
        xact(0, 1, 19'h00800, 16'h5555, 2'b11, lat, rd);
        exp_q.push_back(16'hAAAA);
        xact(0, 0, 19'h00000, 16'h0000, 2'b11, lat, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin errors++; $display("FAIL oor_write_dropped: got %h want %h", rd, e); end
        checks++; if (d0_oor !== 1'b1) begin errors++; $display("FAIL oor_sticky: got %b want 1", d0_oor); end
        checks++; if ({d0_rd, d0_wr} !== {16'd2, 16'd1}) begin
            errors++; $display("FAIL oor_counts: got rd=%0d wr=%0d want rd=2 wr=1", d0_rd, d0_wr);
        end
        do_reset();
        checks++; if (d0_oor !== 1'b0) begin errors++; $display("FAIL oor_cleared: got %b want 0", d0_oor); end
    endtask

    task automatic test_reset_abort;
        int lat, seen;
        logic [15:0] rd, e;
        do_reset();
        seen = 0;
        @(negedge clk);
        m_addr = 19'h00010;
        m_data_out = 16'hBEEF;
        m_wr_en = 1'b1;
        m_bytesel = 2'b11;
        m_access3 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        m_access3 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (d3_ack === 1'b1) seen++;
            if (k == 2) reset = 1'b0;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_ack: got %0d acks want 0", seen); end
        checks++; if ({d3_rd, d3_wr} !== 32'd0) begin
            errors++; $display("FAIL abort_counts: got rd=%0d wr=%0d want 0", d3_rd, d3_wr);
        end
        exp_q.push_back(16'hAAAA);
        xact(1, 0, 19'h00010, 16'h0000, 2'b11, lat, rd);
        e = exp_q.pop_front();
        checks++; if (rd !== e) begin errors++; $display("FAIL abort_no_write: got %h want %h", rd, e); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL abort_then_latency: got %0d want 4", lat); end
    endtask

    task automatic run_batch(input int run);
        int lat;
        logic [15:0] rd, e;
        logic [18:0] a;
        do_reset();
        for (int i = 0; i < 64; i++) begin
            a = 19'h00100 + 19'($urandom_range(0, 255));
            exp_q.push_back(16'hAAAA);
            xact(0, 0, a, 16'h0000, 2'b11, lat, rd);
            e = exp_q.pop_front();
            checks++; if (rd !== e) begin errors++; $display("FAIL batch_read[%0d]: got %h want %h", i, rd, e); end
            if (run == 0) lat_a[i] = lat;
            else          lat_b[i] = lat;
        end
        checks++; if (d0_rd !== 16'd64) begin errors++; $display("FAIL batch_rd_count: got %0d want 64", d0_rd); end
    endtask

    task automatic test_latency_batch;
        int stalled;
        stalled = 0;
        run_batch(0);
`ifdef RESP_STALL_EN
        run_batch(1);
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (lat_a[i] < 1 || lat_a[i] > 4) begin
                errors++; $display("FAIL stall_range[%0d]: got %0d want 1..4", i, lat_a[i]);
            end
            checks++;
            if (lat_a[i] !== lat_b[i]) begin
                errors++; $display("FAIL stall_repeat[%0d]: got %0d want %0d", i, lat_b[i], lat_a[i]);
            end
            if (lat_a[i] > 1) stalled++;
        end
        checks++;
        if (stalled == 0) begin errors++; $display("FAIL stall_present: got 0 stalled reads want >0"); end
`else
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (lat_a[i] !== 1) begin
                errors++; $display("FAIL fixed_latency[%0d]: got %0d want 1", i, lat_a[i]);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_rw_bytes();
        test_wait_hold();
        test_oor();
        test_reset_abort();
        test_latency_batch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
